axi_stream_constant_checker: RTL and testbench
==============================================

AXI_STREAM_CONSTANT_CHECKER -- requirements
Module: axi_stream_constant_checker

Interface
REQ-001 Parameter C_DATA_IN_DATA_WIDTH, default 8, SHALL set the stream data width; legal range 1..32.
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32, SHALL set the AXI4-Lite data width; only 32 is legal, with an elaboration error otherwise.
REQ-003 Parameter C_S_AXI_ADDR_WIDTH, default 5, SHALL set the AXI4-Lite address width; values below 5 SHALL raise an elaboration error.
REQ-004 aclk, input, 1: clock; all logic is rising-edge.
REQ-005 resetn, input, 1: reset, synchronous, active-low.
REQ-006 data_in_tvalid, input, 1: stream beat valid.
REQ-007 data_in_tdata, input, C_DATA_IN_DATA_WIDTH: stream beat data.
REQ-008 data_in_tready, output, 1: the checker accepts the beat.
REQ-009 s_axi_aw*/w*/b*/ar*/r* SHALL be a standard AXI4-Lite slave: awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready.

Function
REQ-010 Register map, byte address, address bits [4:2] decoded:
- 0x00 EXPECT: RW, low C_DATA_IN_DATA_WIDTH bits used.
- 0x04 TARGET: RW, 32-bit beat count.
- 0x08 RECEIVED: RO.
- 0x0C ERRORS: RO.
- 0x10 FIRST_ERR_INDEX: RO.
- 0x14 FIRST_ERR_DATA: RO.
- 0x18 CONTROL: write bit0=START, bit1=CLEAR; read bit0=RUN, bit1=DONE, bit2=ERR.
REQ-011 Write handshake: awready and wready SHALL assert together for one cycle when awvalid and wvalid are both high and bvalid is low.
REQ-012 The write handshake SHALL be followed by bvalid in the next cycle with bresp=00, held until bready.
REQ-013 Read handshake: arready SHALL assert for one cycle when arvalid is high and rvalid is low.
REQ-014 The read handshake SHALL be followed by rvalid in the next cycle with rresp=00 and rdata sampled at the handshake, held until rready.
REQ-015 Unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-016 wstrb SHALL be honoured per byte for EXPECT and TARGET; unused EXPECT bits SHALL read 0.
REQ-017 The state machine SHALL have three states: IDLE, RUN, DONE.
REQ-018 A CONTROL write with START=1 from any state SHALL, on the next cycle:
- enter RUN;
- zero RECEIVED, ERRORS, FIRST_ERR_INDEX, FIRST_ERR_DATA;
- clear ERR.
REQ-019 A CONTROL write with CLEAR=1 SHALL do the same but enter IDLE; CLEAR takes priority over START in the same write.
REQ-020 Writes to EXPECT or TARGET while in RUN SHALL be ignored, with bresp still 00.
REQ-021 data_in_tready SHALL equal (state==RUN) AND (RECEIVED < TARGET) AND (no CONTROL write accepted this cycle).
REQ-022 Each beat (tvalid & tready) SHALL increment RECEIVED by 1.
REQ-023 If a beat's tdata differs from EXPECT, ERRORS SHALL increment, saturating at 0xFFFFFFFF.
REQ-024 On the first mismatch since START or CLEAR, FIRST_ERR_INDEX SHALL capture the pre-increment RECEIVED, FIRST_ERR_DATA SHALL capture tdata zero-extended, and ERR SHALL set.
REQ-025 RUN SHALL transition to DONE in the cycle after RECEIVED equals TARGET.
- TARGET=0: DONE is reached 2 cycles after the START write with no beats accepted.
REQ-026 DONE SHALL persist until the next START or CLEAR; tready SHALL remain 0 in IDLE and DONE.
REQ-027 Reads of RECEIVED and ERRORS SHALL return values consistent with the same clock edge.

Reset
REQ-028 While resetn=0, the block SHALL:
- force state IDLE;
- zero all registers and counters;
- clear ERR;
- drive data_in_tready, awready, wready, bvalid, arready, rvalid low;
- drive bresp, rresp, rdata to 0.
REQ-029 Reset asserted mid-transfer SHALL abort without completing any pending AXI response; the first post-reset cycle SHALL accept new handshakes.

Verification
REQ-030 EXPECT=0xA5, TARGET=4, START, feed 4 beats 0xA5 with tvalid held high -> RECEIVED=4, ERRORS=0, CONTROL reads 0x2, and tready low after the 4th beat.
REQ-031 EXPECT=0x3C, TARGET=5, beats 3C,3C,11,3C,22 -> ERRORS=2, FIRST_ERR_INDEX=2, FIRST_ERR_DATA=0x11, CONTROL reads 0x6.
REQ-032 TARGET=0, START -> tready never high, and CONTROL reads 0x2 within 3 cycles.
REQ-033 Random tvalid gaps plus random bready/rready backpressure, TARGET=100 -> exactly 100 beats accepted, and every bvalid/rvalid held until its ready.
REQ-034 Write EXPECT=0xFF during RUN, then CLEAR mid-run after 3 beats -> EXPECT unchanged, then CONTROL reads 0x0, RECEIVED=0, tready=0.
REQ-035 resetn low for 1 cycle during RUN with an outstanding bvalid -> bvalid, tready low, and all registers read 0 afterwards.

Source files
------------

// File: rtl/axi_stream_constant_checker_if.sv
// Bus bundle for the constant checker: the checked input stream plus the
// AXI4-Lite control/status port, seen from the checker (slave) or its driver (master).
interface axi_stream_constant_checker_if #(
    parameter int C_DATA_IN_DATA_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_S_AXI_ADDR_WIDTH   = 5
);
    logic                              data_in_tvalid;
    logic [C_DATA_IN_DATA_WIDTH-1:0]   data_in_tdata;
    logic                              data_in_tready;

    logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr;
    logic                              s_axi_awvalid;
    logic                              s_axi_awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb;
    logic                              s_axi_wvalid;
    logic                              s_axi_wready;
    logic [1:0]                        s_axi_bresp;
    logic                              s_axi_bvalid;
    logic                              s_axi_bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr;
    logic                              s_axi_arvalid;
    logic                              s_axi_arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata;
    logic [1:0]                        s_axi_rresp;
    logic                              s_axi_rvalid;
    logic                              s_axi_rready;

    modport slave (
        input  data_in_tvalid, data_in_tdata,
        output data_in_tready,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output data_in_tvalid, data_in_tdata,
        input  data_in_tready,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_stream_constant_checker.sv
// Counts stream beats up to a programmed target and flags every beat whose
// data differs from a programmed constant; controlled over AXI4-Lite.
module axi_stream_constant_checker #(
    parameter int C_DATA_IN_DATA_WIDTH = 8,
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_S_AXI_ADDR_WIDTH   = 5
) (
    input  logic                          aclk,
    input  logic                          resetn,
    axi_stream_constant_checker_if.slave  s_if
);
    if (C_DATA_IN_DATA_WIDTH < 1 || C_DATA_IN_DATA_WIDTH > 32) begin : g_bad_data_width
        $error("C_DATA_IN_DATA_WIDTH must be in 1..32");
    end
    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_axi_width
        $error("C_S_AXI_DATA_WIDTH must be 32");
    end
    if (C_S_AXI_ADDR_WIDTH < 5) begin : g_bad_addr_width
        $error("C_S_AXI_ADDR_WIDTH must be at least 5");
    end

    localparam int DW = C_DATA_IN_DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [2:0] REG_EXPECT     = 3'd0;
    localparam logic [2:0] REG_TARGET     = 3'd1;
    localparam logic [2:0] REG_RECEIVED   = 3'd2;
    localparam logic [2:0] REG_ERRORS     = 3'd3;
    localparam logic [2:0] REG_FIRST_IDX  = 3'd4;
    localparam logic [2:0] REG_FIRST_DATA = 3'd5;
    localparam logic [2:0] REG_CONTROL    = 3'd6;

    state_t        r_state;
    state_t        w_state_next;

    logic          r_awready;
    logic          r_bvalid;
    logic          r_arready;
    logic          r_rvalid;
    logic [31:0]   r_rdata;

    logic [DW-1:0] r_expect;
    logic [31:0]   r_target;
    logic [31:0]   r_received;
    logic [31:0]   r_errors;
    logic [31:0]   r_first_idx;
    logic [31:0]   r_first_data;
    logic          r_err;

    logic          w_wr_en;
    logic          w_rd_en;
    logic [2:0]    w_wr_idx;
    logic [2:0]    w_rd_idx;
    logic          w_ctrl_wr;
    logic          w_start;
    logic          w_clear;
    logic          w_cfg_wr;
    logic          w_beat;
    logic          w_tready;
    logic [31:0]   w_expect_wr;
    logic [31:0]   w_target_wr;
    logic [31:0]   w_rd_data;
    logic          w_unused_addr;

    assign w_wr_idx  = s_if.s_axi_awaddr[4:2];
    assign w_rd_idx  = s_if.s_axi_araddr[4:2];
    assign w_wr_en   = r_awready & s_if.s_axi_awvalid & s_if.s_axi_wvalid;
    assign w_rd_en   = r_arready & s_if.s_axi_arvalid;
    assign w_ctrl_wr = w_wr_en && (w_wr_idx == REG_CONTROL);
    assign w_clear   = w_ctrl_wr & s_if.s_axi_wdata[1];
    assign w_start   = w_ctrl_wr & s_if.s_axi_wdata[0];
    assign w_cfg_wr  = w_wr_en && (r_state != ST_RUN);

    // A CONTROL write in flight blocks the stream so a restart never races a beat.
    assign w_tready = (r_state == ST_RUN) && (r_received < r_target) && !w_ctrl_wr;
    assign w_beat   = s_if.data_in_tvalid & w_tready;

    assign w_unused_addr = ^{s_if.s_axi_awaddr, s_if.s_axi_araddr};

    assign s_if.data_in_tready = w_tready;
    assign s_if.s_axi_awready  = r_awready;
    assign s_if.s_axi_wready   = r_awready;
    assign s_if.s_axi_bvalid   = r_bvalid;
    assign s_if.s_axi_bresp    = 2'b00;
    assign s_if.s_axi_arready  = r_arready;
    assign s_if.s_axi_rvalid   = r_rvalid;
    assign s_if.s_axi_rdata    = r_rdata;
    assign s_if.s_axi_rresp    = 2'b00;

    always_ff @(posedge aclk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (w_clear)
            w_state_next = ST_IDLE;
        else if (w_start)
            w_state_next = ST_RUN;
        else if (r_state == ST_RUN && r_received == r_target)
            w_state_next = ST_DONE;
    end

    // Byte-strobed merge of the write data into the current register values.
    always_comb begin
        w_expect_wr = 32'(r_expect);
        w_target_wr = r_target;
        for (int b = 0; b < 4; b++) begin
            if (s_if.s_axi_wstrb[b]) begin
                w_expect_wr[8*b +: 8] = s_if.s_axi_wdata[8*b +: 8];
                w_target_wr[8*b +: 8] = s_if.s_axi_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (w_rd_idx)
            REG_EXPECT:     w_rd_data = 32'(r_expect);
            REG_TARGET:     w_rd_data = r_target;
            REG_RECEIVED:   w_rd_data = r_received;
            REG_ERRORS:     w_rd_data = r_errors;
            REG_FIRST_IDX:  w_rd_data = r_first_idx;
            REG_FIRST_DATA: w_rd_data = r_first_data;
            REG_CONTROL:    w_rd_data = {29'd0, r_err, r_state == ST_DONE, r_state == ST_RUN};
            default:        w_rd_data = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_awready <= s_if.s_axi_awvalid & s_if.s_axi_wvalid & ~r_bvalid & ~r_awready;
            if (w_wr_en)
                r_bvalid <= 1'b1;
            else if (s_if.s_axi_bready)
                r_bvalid <= 1'b0;

            r_arready <= s_if.s_axi_arvalid & ~r_rvalid & ~r_arready;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s_if.s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_expect     <= '0;
            r_target     <= 32'd0;
            r_received   <= 32'd0;
            r_errors     <= 32'd0;
            r_first_idx  <= 32'd0;
            r_first_data <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            if (w_start || w_clear) begin
                r_received   <= 32'd0;
                r_errors     <= 32'd0;
                r_first_idx  <= 32'd0;
                r_first_data <= 32'd0;
                r_err        <= 1'b0;
            end else if (w_beat) begin
                r_received <= r_received + 32'd1;
                if (s_if.data_in_tdata != r_expect) begin
                    if (r_errors != 32'hFFFF_FFFF)
                        r_errors <= r_errors + 32'd1;
                    if (!r_err) begin
                        r_first_idx  <= r_received;
                        r_first_data <= 32'(s_if.data_in_tdata);
                        r_err        <= 1'b1;
                    end
                end
            end

            if (w_cfg_wr && w_wr_idx == REG_EXPECT)
                r_expect <= w_expect_wr[DW-1:0];
            if (w_cfg_wr && w_wr_idx == REG_TARGET)
                r_target <= w_target_wr;
        end
    end
endmodule

// File: tb/tb_axi_stream_constant_checker.sv
// Directed + randomized bench for axi_stream_constant_checker; expected
// register values come from a queue-based model of the accepted beats.
module tb_axi_stream_constant_checker;
    localparam logic [4:0] A_EXPECT = 5'h00, A_TARGET = 5'h04, A_RECEIVED = 5'h08,
                           A_ERRORS = 5'h0C, A_FIDX = 5'h10, A_FDATA = 5'h14,
                           A_CONTROL = 5'h18, A_UNMAPPED = 5'h1C;

    logic aclk;
    logic resetn;

    axi_stream_constant_checker_if #(
        .C_DATA_IN_DATA_WIDTH(8), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)
    ) bus ();

    axi_stream_constant_checker #(
        .C_DATA_IN_DATA_WIDTH(8), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .aclk   (aclk),
        .resetn (resetn),
        .s_if   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tready_hi_cnt = 0;
    int wr_hs_cyc;
    int rd_hs_cyc;

    logic [7:0] tx_q[$];
    logic [7:0] acc_q[$];

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;
    always @(negedge aclk) if (bus.data_in_tready) tready_hi_cnt <= tready_hi_cnt + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Responses must stay put while the master stalls them.
    logic p_bvalid = 0, p_bready = 0, p_rvalid = 0, p_rready = 0, p_resetn = 0;
    logic [31:0] p_rdata = 0;
    always @(negedge aclk) begin
        if (p_resetn && p_bvalid && !p_bready) check("bvalid_hold", 32'(bus.s_axi_bvalid), 32'd1);
        if (p_resetn && p_rvalid && !p_rready) begin
            check("rvalid_hold", 32'(bus.s_axi_rvalid), 32'd1);
            check("rdata_hold", bus.s_axi_rdata, p_rdata);
        end
        p_bvalid <= bus.s_axi_bvalid;
        p_bready <= bus.s_axi_bready;
        p_rvalid <= bus.s_axi_rvalid;
        p_rready <= bus.s_axi_rready;
        p_rdata  <= bus.s_axi_rdata;
        p_resetn <= resetn;
    end

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int bdelay, input bit skip_b);
        bit ok = 0;
        int d;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_wdata   = data;
        bus.s_axi_wstrb   = strb;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bus.s_axi_awready && bus.s_axi_wready) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        wr_hs_cyc = cyc;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        check("aw_handshake", 32'(ok), 32'd1);
        if (!skip_b) begin
            d = (bdelay < 0) ? int'($urandom_range(0, 3)) : bdelay;
            repeat (d) begin @(posedge aclk); #1; end
            bus.s_axi_bready = 1'b1;
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge aclk);
                if (bus.s_axi_bvalid) begin ok = 1; break; end
            end
            check("bvalid_seen", 32'(ok), 32'd1);
            check("bresp", 32'(bus.s_axi_bresp), 32'd0);
            @(posedge aclk); #1;
            bus.s_axi_bready = 1'b0;
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        axi_write(addr, data, 4'hF, -1, 1'b0);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        bit ok = 0;
        int d;
        data = 32'hDEAD_BEEF;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bus.s_axi_arready) begin ok = 1; break; end
        end
        @(posedge aclk); #1;
        rd_hs_cyc = cyc;
        bus.s_axi_arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 32'd1);
        d = $urandom_range(0, 3);
        repeat (d) begin @(posedge aclk); #1; end
        bus.s_axi_rready = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bus.s_axi_rvalid) begin ok = 1; data = bus.s_axi_rdata; break; end
        end
        check("rvalid_seen", 32'(ok), 32'd1);
        check("rresp", 32'(bus.s_axi_rresp), 32'd0);
        @(posedge aclk); #1;
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        logic [31:0] v;
        axi_read(addr, v);
        check(tag, v, expected);
    endtask

    // Presents tx_q in order (valid held until accepted), logging accepted beats into acc_q.
    task automatic stream_send(input int gap_pct, input int budget, output int n_acc);
        int idx = 0;
        bit fire;
        n_acc = 0;
        for (int c = 0; c < budget && idx < tx_q.size(); c++) begin
            if (!bus.data_in_tvalid && $urandom_range(0, 99) >= gap_pct) begin
                bus.data_in_tvalid = 1'b1;
                bus.data_in_tdata  = tx_q[idx];
            end
            @(negedge aclk);
            fire = bus.data_in_tvalid && bus.data_in_tready;
            @(posedge aclk); #1;
            if (fire) begin
                acc_q.push_back(bus.data_in_tdata);
                idx++;
                n_acc++;
                bus.data_in_tvalid = 1'b0;
            end
        end
        bus.data_in_tvalid = 1'b0;
    endtask

    // Reference: what the status registers must hold after acc_q was consumed.
    task automatic check_model(input string tag, input logic [7:0] exp_val, input bit done);
        logic [31:0] errs = 0, fidx = 0, fdata = 0;
        bit err = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i] != exp_val) begin
                if (!err) begin fidx = i; fdata = {24'd0, acc_q[i]}; err = 1; end
                errs++;
            end
        end
        rd_check({tag, "_received"}, A_RECEIVED, acc_q.size());
        rd_check({tag, "_errors"},   A_ERRORS,   errs);
        rd_check({tag, "_fidx"},     A_FIDX,     fidx);
        rd_check({tag, "_fdata"},    A_FDATA,    fdata);
        rd_check({tag, "_control"},  A_CONTROL,  {29'd0, err, done, !done});
    endtask

    initial begin
        int n_acc;
        int base;
        logic [7:0] ev;

        resetn = 1'b0;
        bus.data_in_tvalid = 0; bus.data_in_tdata = 0;
        bus.s_axi_awaddr = 0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wstrb = 0;
        bus.s_axi_wvalid = 0; bus.s_axi_bready = 0; bus.s_axi_araddr = 0; bus.s_axi_arvalid = 0;
        bus.s_axi_rready = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tready",  32'(bus.data_in_tready), 32'd0);
        check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
        check("rst_bvalid",  32'(bus.s_axi_bvalid), 32'd0);
        check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
        check("rst_rvalid",  32'(bus.s_axi_rvalid), 32'd0);
        check("rst_rdata",   bus.s_axi_rdata, 32'd0);
        @(posedge aclk); #1;
        resetn = 1'b1;
        for (int a = 0; a < 8; a++) rd_check($sformatf("rst_reg%0d", a), 5'(a * 4), 32'd0);

        // Byte strobes, unused EXPECT bits, unmapped address.
        wr(A_TARGET, 32'hAABB_CCDD);
        axi_write(A_TARGET, 32'h1122_3344, 4'b0101, -1, 1'b0);
        rd_check("target_strb", A_TARGET, 32'hAA22_CC44);
        wr(A_EXPECT, 32'hFFFF_FF5A);
        rd_check("expect_width", A_EXPECT, 32'h0000_005A);
        axi_write(A_EXPECT, 32'h0000_0077, 4'b0000, -1, 1'b0);
        rd_check("expect_nostrb", A_EXPECT, 32'h0000_005A);
        wr(A_UNMAPPED, 32'h1234_5678);
        rd_check("unmapped", A_UNMAPPED, 32'd0);

        // All-match run with tvalid held high.
        wr(A_EXPECT, 32'hA5);
        wr(A_TARGET, 32'd4);
        wr(A_CONTROL, 32'h1);
        tx_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
        acc_q.delete();
        stream_send(0, 50, n_acc);
        check("match_accepted", n_acc, 32'd4);
        @(negedge aclk);
        check("match_tready_after_last", 32'(bus.data_in_tready), 32'd0);
        rd_check("match_received", A_RECEIVED, 32'd4);
        rd_check("match_errors", A_ERRORS, 32'd0);
        rd_check("match_control", A_CONTROL, 32'h2);

        // Two mismatches, first at index 2.
        wr(A_EXPECT, 32'h3C);
        wr(A_TARGET, 32'd5);
        wr(A_CONTROL, 32'h1);
        tx_q = '{8'h3C, 8'h3C, 8'h11, 8'h3C, 8'h22};
        acc_q.delete();
        stream_send(30, 200, n_acc);
        check("mis_accepted", n_acc, 32'd5);
        repeat (2) @(posedge aclk);
        #1;
        rd_check("mis_errors", A_ERRORS, 32'd2);
        rd_check("mis_fidx", A_FIDX, 32'd2);
        rd_check("mis_fdata", A_FDATA, 32'h11);
        rd_check("mis_control", A_CONTROL, 32'h6);
        check_model("mis_model", 8'h3C, 1'b1);

        // TARGET=0 completes with no beats.
        wr(A_TARGET, 32'd0);
        base = tready_hi_cnt;
        bus.data_in_tvalid = 1'b1;
        bus.data_in_tdata  = 8'h3C;
        axi_write(A_CONTROL, 32'h1, 4'hF, 0, 1'b0);
        rd_check("t0_control", A_CONTROL, 32'h2);
        check("t0_latency_ok", 32'((rd_hs_cyc - wr_hs_cyc) <= 3), 32'd1);
        bus.data_in_tvalid = 1'b0;
        check("t0_tready_never", tready_hi_cnt - base, 32'd0);
        rd_check("t0_received", A_RECEIVED, 32'd0);

        // Long random run with gaps and response backpressure.
        ev = 8'($urandom);
        wr(A_EXPECT, {24'd0, ev});
        wr(A_TARGET, 32'd100);
        wr(A_CONTROL, 32'h1);
        tx_q.delete();
        for (int i = 0; i < 100; i++) tx_q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : ev);
        acc_q.delete();
        stream_send(40, 2000, n_acc);
        check("rand_accepted", n_acc, 32'd100);
        tx_q = '{8'h00};
        stream_send(0, 10, n_acc);
        check("rand_extra_rejected", n_acc, 32'd0);
        check_model("rand_model", ev, 1'b1);

        // Config writes ignored in RUN; CLEAR mid-run.
        wr(A_EXPECT, 32'h5A);
        wr(A_TARGET, 32'd10);
        wr(A_CONTROL, 32'h1);
        tx_q = '{8'h5A, 8'h00, 8'h5A};
        acc_q.delete();
        stream_send(0, 50, n_acc);
        check("clr_accepted", n_acc, 32'd3);
        wr(A_EXPECT, 32'hFF);
        wr(A_TARGET, 32'd7);
        check_model("clr_midrun", 8'h5A, 1'b0);
        wr(A_CONTROL, 32'h2);
        rd_check("clr_expect_kept", A_EXPECT, 32'h5A);
        rd_check("clr_target_kept", A_TARGET, 32'd10);
        rd_check("clr_control", A_CONTROL, 32'h0);
        rd_check("clr_received", A_RECEIVED, 32'd0);
        rd_check("clr_errors", A_ERRORS, 32'd0);
        @(negedge aclk);
        check("clr_tready", 32'(bus.data_in_tready), 32'd0);
        wr(A_CONTROL, 32'h1);
        wr(A_CONTROL, 32'h3);
        rd_check("clr_beats_start", A_CONTROL, 32'h0);

        // Reset during RUN with a stalled write response.
        wr(A_CONTROL, 32'h1);
        axi_write(A_EXPECT, 32'h12, 4'hF, 0, 1'b1);
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bus.s_axi_bvalid) begin n_acc = 1; break; end
        end
        check("rst_bvalid_pending", n_acc, 32'd1);
        @(posedge aclk); #1;
        resetn = 1'b0;
        @(posedge aclk); #1;
        resetn = 1'b1;
        @(negedge aclk);
        check("rst2_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        check("rst2_tready", 32'(bus.data_in_tready), 32'd0);
        for (int a = 0; a < 7; a++) rd_check($sformatf("rst2_reg%0d", a), 5'(a * 4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
